// File: rtl/mem_test_initiator_if.sv
// mem_test_initiator_if
//   Valid/ready memory bus between the self-test initiator and the memory.
//   Signal names are from the initiator's point of view.
//   addr_o   : word address
//   wr_rd_o  : 1=write, 0=read
//   wdata_o  : write data
//   valid_o  : one-cycle request pulse
//   ready_i  : response strobe from the memory
//   rdata_i  : read data, valid while ready_i=1 on a read
//   Modports: master (initiator), slave (memory).
interface mem_test_initiator_if #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 5
) ();
    logic [ADDR_WIDTH-1:0] addr_o;
    logic                  wr_rd_o;
    logic [WIDTH-1:0]      wdata_o;
    logic                  valid_o;
    logic                  ready_i;
    logic [WIDTH-1:0]      rdata_i;

    modport master (output addr_o, wr_rd_o, wdata_o, valid_o, input ready_i, rdata_i);
    modport slave  (input addr_o, wr_rd_o, wdata_o, valid_o, output ready_i, rdata_i);
endinterface

// File: rtl/mem_test_initiator.sv
// mem_test_initiator
//   Memory self-test initiator: writes D(k)=seed+k over [base, base+len) (address
//   wrapping mod DEPTH), reads the range back and counts mismatching words.
//   Optional macro MEM_TEST_INV_PASS_EN adds a second write/read pass with ~D(k).
// Ports
//   clk_i, rst_i           : clock, synchronous active-high reset
//   start_i                : start a run (only looked at while idle)
//   base_addr_i/len_i/seed_i : run parameters, captured on start
//   mem_if (master)        : valid/ready memory bus
//   busy_o, done_o         : run in progress / one-cycle end-of-run pulse
//   pass_o, timeout_o      : run result, held until the next accepted start
//   err_cnt_o              : saturating mismatch count
//   first_err_addr_o       : address of the first mismatch in the run
module mem_test_initiator #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int TIMEOUT    = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic [ADDR_WIDTH-1:0]   base_addr_i,
    input  logic [ADDR_WIDTH:0]     len_i,
    input  logic [WIDTH-1:0]        seed_i,
    mem_test_initiator_if.master    mem_if,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    pass_o,
    output logic                    timeout_o,
    output logic [CNT_WIDTH-1:0]    err_cnt_o,
    output logic [ADDR_WIDTH-1:0]   first_err_addr_o
);
    localparam int WC_W = $clog2(TIMEOUT);

    typedef enum logic [3:0] {
        IDLE,
        WR_ISSUE,
        WR_WAIT,
        RD_ISSUE,
        RD_WAIT,
`ifdef MEM_TEST_INV_PASS_EN
        WRI_ISSUE,
        WRI_WAIT,
        RDI_ISSUE,
        RDI_WAIT,
`endif
        DONE
    } state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   base_q;
    logic [ADDR_WIDTH:0]     len_q;
    logic [WIDTH-1:0]        seed_q;
    logic [ADDR_WIDTH:0]     k_q;
    logic [WC_W-1:0]         wcnt_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    wr_q;
    logic [WIDTH-1:0]        wdata_q;
    logic                    valid_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    pass_q;
    logic                    timeout_q;
    logic [CNT_WIDTH-1:0]    err_cnt_q;
    logic [CNT_WIDTH-1:0]    err_cnt_d;
    logic [ADDR_WIDTH-1:0]   first_err_q;

    // (base + k) mod DEPTH without a divider: base < DEPTH and k < DEPTH,
    // so one conditional subtract is enough.
    function automatic logic [ADDR_WIDTH-1:0] addr_of(input logic [ADDR_WIDTH-1:0] b,
                                                      input logic [ADDR_WIDTH:0]   k);
        logic [ADDR_WIDTH+1:0] s;
        s = {2'b00, b} + {1'b0, k};
        if (s >= (ADDR_WIDTH+2)'(DEPTH))
            s = s - (ADDR_WIDTH+2)'(DEPTH);
        return s[ADDR_WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] data_of(input logic [WIDTH-1:0]  s,
                                                 input logic [ADDR_WIDTH:0] k,
                                                 input logic                inv);
        logic [WIDTH-1:0] d;
        d = s + WIDTH'(k);
        return inv ? ~d : d;
    endfunction

    // Phase decode: which WAIT we are in, what to re-issue within the phase,
    // and which ISSUE state opens the following phase (DONE when none).
    logic   in_wait, is_issue, rd_phase, inv_phase, nxt_wr, nxt_inv;
    state_t cur_issue, nxt_issue, own_wait;

    always_comb begin
        in_wait   = 1'b0;
        is_issue  = 1'b0;
        rd_phase  = 1'b0;
        inv_phase = 1'b0;
        nxt_wr    = 1'b0;
        nxt_inv   = 1'b0;
        cur_issue = WR_ISSUE;
        nxt_issue = DONE;
        own_wait  = IDLE;
        case (state_q)
            WR_ISSUE: begin is_issue = 1'b1; own_wait = WR_WAIT; end
            RD_ISSUE: begin is_issue = 1'b1; own_wait = RD_WAIT; end
            WR_WAIT:  begin in_wait = 1'b1; cur_issue = WR_ISSUE; nxt_issue = RD_ISSUE; end
            RD_WAIT: begin
                in_wait   = 1'b1;
                rd_phase  = 1'b1;
                cur_issue = RD_ISSUE;
`ifdef MEM_TEST_INV_PASS_EN
                nxt_issue = WRI_ISSUE;
                nxt_wr    = 1'b1;
                nxt_inv   = 1'b1;
`endif
            end
`ifdef MEM_TEST_INV_PASS_EN
            WRI_ISSUE: begin is_issue = 1'b1; own_wait = WRI_WAIT; end
            RDI_ISSUE: begin is_issue = 1'b1; own_wait = RDI_WAIT; end
            WRI_WAIT: begin
                in_wait = 1'b1; inv_phase = 1'b1;
                cur_issue = WRI_ISSUE; nxt_issue = RDI_ISSUE; nxt_inv = 1'b1;
            end
            RDI_WAIT: begin
                in_wait = 1'b1; rd_phase = 1'b1; inv_phase = 1'b1;
                cur_issue = RDI_ISSUE;
            end
`endif
            default: ;
        endcase
    end

    logic [WIDTH-1:0]    exp_word;
    logic                mismatch;
    logic                last_word;
    logic [ADDR_WIDTH:0] k_nxt;

    assign exp_word  = data_of(seed_q, k_q, inv_phase);
    assign mismatch  = in_wait && rd_phase && mem_if.ready_i && (mem_if.rdata_i != exp_word);
    assign err_cnt_d = (mismatch && !(&err_cnt_q)) ? err_cnt_q + 1'b1 : err_cnt_q;
    assign last_word = (k_q == len_q - 1'b1);
    assign k_nxt     = k_q + 1'b1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            base_q      <= '0;
            len_q       <= '0;
            seed_q      <= '0;
            k_q         <= '0;
            wcnt_q      <= '0;
            addr_q      <= '0;
            wr_q        <= 1'b0;
            wdata_q     <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            timeout_q   <= 1'b0;
            err_cnt_q   <= '0;
            first_err_q <= '0;
        end else begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: if (start_i) begin
                    base_q      <= base_addr_i;
                    len_q       <= len_i;
                    seed_q      <= seed_i;
                    k_q         <= '0;
                    err_cnt_q   <= '0;
                    first_err_q <= '0;
                    timeout_q   <= 1'b0;
                    pass_q      <= 1'b0;
                    busy_q      <= 1'b1;
                    if (len_i == '0) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        pass_q  <= 1'b1;
                    end else begin
                        state_q <= WR_ISSUE;
                        valid_q <= 1'b1;
                        addr_q  <= base_addr_i;
                        wr_q    <= 1'b1;
                        wdata_q <= seed_i;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    if (is_issue) begin
                        // ready_i is not looked at here; the request is already on the bus.
                        wcnt_q  <= '0;
                        state_q <= own_wait;
                    end else if (in_wait) begin
                        if (mem_if.ready_i) begin
                            err_cnt_q <= err_cnt_d;
                            if (mismatch && err_cnt_q == '0)
                                first_err_q <= addr_q;
                            if (!last_word) begin
                                k_q     <= k_nxt;
                                state_q <= cur_issue;
                                valid_q <= 1'b1;
                                addr_q  <= addr_of(base_q, k_nxt);
                                wr_q    <= !rd_phase;
                                wdata_q <= rd_phase ? '0 : data_of(seed_q, k_nxt, inv_phase);
                            end else if (nxt_issue == DONE) begin
                                state_q <= DONE;
                                done_q  <= 1'b1;
                                pass_q  <= (err_cnt_d == '0);
                                addr_q  <= '0;
                                wr_q    <= 1'b0;
                                wdata_q <= '0;
                            end else begin
                                k_q     <= '0;
                                state_q <= nxt_issue;
                                valid_q <= 1'b1;
                                addr_q  <= base_q;
                                wr_q    <= nxt_wr;
                                wdata_q <= nxt_wr ? data_of(seed_q, '0, nxt_inv) : '0;
                            end
                        end else if (wcnt_q == WC_W'(TIMEOUT - 1)) begin
                            // Abort: no further requests, result is a fail.
                            timeout_q <= 1'b1;
                            state_q   <= DONE;
                            done_q    <= 1'b1;
                            pass_q    <= 1'b0;
                            addr_q    <= '0;
                            wr_q      <= 1'b0;
                            wdata_q   <= '0;
                        end else begin
                            wcnt_q <= wcnt_q + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign mem_if.addr_o    = addr_q;
    assign mem_if.wr_rd_o   = wr_q;
    assign mem_if.wdata_o   = wdata_q;
    assign mem_if.valid_o   = valid_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign pass_o           = pass_q;
    assign timeout_o        = timeout_q;
    assign err_cnt_o        = err_cnt_q;
    assign first_err_addr_o = first_err_q;
endmodule

// File: tb/tb_mem_test_initiator.sv
module tb_mem_test_initiator;
    localparam int WIDTH = 32;
    localparam int DEPTH = 32;
    localparam int AW    = 5;
`ifdef MEM_TEST_INV_PASS_EN
    localparam int PHASES = 4;
`else
    localparam int PHASES = 2;
`endif

    typedef struct {
        logic [AW-1:0]    addr;
        logic             wr;
        logic [WIDTH-1:0] wdata;
    } tx_t;

    typedef struct {
        int err;
        int first;
        bit pass;
        bit to;
        int lat;
        bit chk_lat;
    } res_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [AW-1:0]    base = '0;
    logic [AW:0]      len = '0;
    logic [WIDTH-1:0] seed = '0;
    logic             busy, done, pass, tout;
    logic [15:0]      errc;
    logic [AW-1:0]    ferr;

    mem_test_initiator_if #(.WIDTH(WIDTH), .ADDR_WIDTH(AW)) mi ();

    mem_test_initiator #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .TIMEOUT(16), .CNT_WIDTH(16)
    ) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start),
        .base_addr_i(base), .len_i(len), .seed_i(seed),
        .mem_if(mi),
        .busy_o(busy), .done_o(done), .pass_o(pass), .timeout_o(tout),
        .err_cnt_o(errc), .first_err_addr_o(ferr)
    );

    always #5 clk = ~clk;

    int  n_cmp = 0, n_fail = 0;
    tx_t txq[$];
    res_t resq[$];
    int  ncyc = 0, start_n = 0, rd_valids = 0, done_seen = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Memory model: answers each request after 0..lat_max extra cycles
    // (0 = one-cycle responder). Can flip rdata bit0 at one address.
    logic [WIDTH-1:0] mem [DEPTH];
    bit  ready_en = 1'b1;
    int  flip_addr = -1;
    int  lat_max = 0;

    initial begin : responder
        bit pend;
        int dly;
        logic [AW-1:0] pa;
        logic pw;
        logic [WIDTH-1:0] pd;
        bit fire;
        pend = 1'b0;
        forever begin
            @(posedge clk);
            fire = 1'b0;
            mi.ready_i <= 1'b0;
            mi.rdata_i <= '0;
            if (rst) begin
                pend = 1'b0;
                for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
            end else if (pend) begin
                if (dly == 0) fire = 1'b1; else dly--;
            end else if (mi.valid_o && ready_en) begin
                pa = mi.addr_o; pw = mi.wr_rd_o; pd = mi.wdata_o;
                dly = (lat_max == 0) ? 0 : $urandom_range(0, lat_max);
                if (dly == 0) fire = 1'b1; else begin pend = 1'b1; dly--; end
            end
            if (fire) begin
                pend = 1'b0;
                mi.ready_i <= 1'b1;
                if (pw) mem[pa] = pd;
                else mi.rdata_i <= mem[pa] ^ ((flip_addr == int'(pa)) ? 32'h1 : 32'h0);
            end
        end
    end

    // Monitor: pops expected requests on every valid_o, expected results on done_o.
    initial begin : monitor
        tx_t t;
        res_t r;
        forever begin
            @(negedge clk);
            ncyc++;
            if (!rst && start && !busy) start_n = ncyc;
            if (mi.valid_o) begin
                if (!mi.wr_rd_o) rd_valids++;
                chk("tx_expected", 64'(txq.size() > 0), 64'd1);
                if (txq.size() > 0) begin
                    t = txq.pop_front();
                    chk("addr_o", 64'(mi.addr_o), 64'(t.addr));
                    chk("wr_rd_o", 64'(mi.wr_rd_o), 64'(t.wr));
                    chk("wdata_o", 64'(mi.wdata_o), 64'(t.wdata));
                end
            end
            if (done) begin
                done_seen++;
                chk("done_expected", 64'(resq.size() > 0), 64'd1);
                if (resq.size() > 0) begin
                    r = resq.pop_front();
                    chk("err_cnt", 64'(errc), 64'(r.err));
                    chk("first_err_addr", 64'(ferr), 64'(r.first));
                    chk("pass_at_done", 64'(pass), 64'(r.pass));
                    chk("timeout", 64'(tout), 64'(r.to));
                    if (r.chk_lat) chk("done_latency", 64'(ncyc - start_n), 64'(r.lat));
                end
            end
        end
    end

    // Reference: the run is PHASES sweeps over the range; even sweeps write,
    // odd sweeps read; sweeps 2/3 use inverted data. Mismatches happen only
    // on reads of flip_addr. Latency counted from the negedge before the start edge.
    task automatic launch(input int b, input int l, input logic [WIDTH-1:0] s,
                          input int flip, input bit ren, input int lat, output bit exp_pass);
        tx_t t;
        res_t r;
        int hits, a;
        hits = 0;
        ready_en = ren; flip_addr = flip; lat_max = lat;
        for (int p = 0; p < PHASES; p++)
            for (int k = 0; k < l; k++) begin
                a = (b + k) % DEPTH;
                t.addr  = AW'(a);
                t.wr    = (p % 2 == 0);
                t.wdata = t.wr ? ((p >= 2) ? ~(s + 32'(k)) : (s + 32'(k))) : '0;
                if (ren || (p == 0 && k == 0)) txq.push_back(t);
                if (!t.wr && a == flip) hits++;
            end
        r.err   = ren ? hits : 0;
        r.first = (ren && hits > 0) ? flip : 0;
        r.to    = !ren && l > 0;
        r.pass  = (r.err == 0) && !r.to;
        r.lat   = (l == 0) ? 1 : (!ren ? 18 : 1 + 2 * PHASES * l);
        r.chk_lat = (lat == 0);
        resq.push_back(r);
        exp_pass = r.pass;
        @(posedge clk); #1;
        start = 1'b1; base = AW'(b); len = (AW+1)'(l); seed = s;
        @(posedge clk); #1;
        start = 1'b0; base = AW'($urandom); len = (AW+1)'($urandom); seed = $urandom;
    endtask

    task automatic run(input string nm, input int b, input int l, input logic [WIDTH-1:0] s,
                       input int flip, input bit ren, input int lat);
        int d0;
        bit ep;
        d0 = done_seen;
        launch(b, l, s, flip, ren, lat, ep);
        for (int i = 0; i < 3000 && done_seen == d0; i++) @(negedge clk);
        chk({nm, "_finished"}, 64'(done_seen != d0), 64'd1);
        @(negedge clk); @(negedge clk);
        chk({nm, "_busy_after"}, 64'(busy), 64'd0);
        chk({nm, "_pass_held"}, 64'(pass), 64'(ep));
        chk({nm, "_tx_left"}, 64'(txq.size()), 64'd0);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_busy"}, 64'(busy), 0);
        chk({nm, "_done"}, 64'(done), 0);
        chk({nm, "_pass"}, 64'(pass), 0);
        chk({nm, "_timeout"}, 64'(tout), 0);
        chk({nm, "_err_cnt"}, 64'(errc), 0);
        chk({nm, "_first_err"}, 64'(ferr), 0);
        chk({nm, "_valid"}, 64'(mi.valid_o), 0);
        chk({nm, "_addr"}, 64'(mi.addr_o), 0);
        chk({nm, "_wr_rd"}, 64'(mi.wr_rd_o), 0);
        chk({nm, "_wdata"}, 64'(mi.wdata_o), 0);
    endtask

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        bit ep;
        int rv0;
        // Reset for 3 cycles.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Full-depth clean run, then memory contents.
        run("full", 0, 32, 32'h1000, -1, 1'b1, 0);
        for (int k = 0; k < DEPTH; k++)
            chk("mem_content", 64'(mem[k]), 64'((PHASES == 4) ? ~(32'h1000 + 32'(k)) : (32'h1000 + 32'(k))));

        // Wrap-around range.
        run("wrap", 30, 4, 32'h1000, -1, 1'b1, 0);

        // Injected read error at address 5.
        run("flip", 0, 8, 32'h0bad_0000, 5, 1'b1, 0);

        // Memory never answers.
        run("timeout", 3, 4, 32'h5555_0000, -1, 1'b0, 0);

        // Reset in the middle of the read phase; a start while busy is ignored.
        rv0 = rd_valids;
        launch(0, 8, 32'h2000, -1, 1'b1, 0, ep);
        @(posedge clk); #1;
        start = 1'b1; base = 5'd7; len = 6'd3; seed = 32'hdead_beef;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 200 && rd_valids < rv0 + 4; i++) @(negedge clk);
        chk("midrst_reached_read3", 64'(rd_valids >= rv0 + 4), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        chk_all_zero("midrst");
        txq.delete();
        resq.delete();
        @(posedge clk); #1;
        rst = 1'b0;

        // Zero-length run.
        run("len0", 9, 0, 32'h1234, -1, 1'b1, 0);

        // Randomized runs, some with slow responses and injected errors.
        for (int n = 0; n < 12; n++)
            run("rand", int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, DEPTH)), $urandom,
                ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, DEPTH - 1)) : -1,
                1'b1, int'($urandom_range(0, 2)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
